romix_dpct_ctrl: RTL and testbench

Sequencer for scrypt ROMix (r = 1, 1024-bit blocks) built around one `blockmix_dpct` instance and an external single-port scratchpad of 2^N_LOG2 × 1024 bits. Phase 1 fills the scratchpad with successive BlockMix states. Phase 2 performs N data-dependent read / XOR / BlockMix iterations. It sits directly upstream of the BlockMix core, driving its `init`/`in` and consuming its `out`/`valid`; the result goes to the PBKDF2 output stage.

---
 rtl/romix_dpct_ctrl.sv | 99 +++++++++
 tb/tb_romix_dpct_ctrl.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/romix_dpct_ctrl.sv
// romix_dpct_ctrl: scrypt ROMix (r=1) sequencer driving one BlockMix core and a single-port scratchpad.
module romix_dpct_ctrl #(
    parameter int N_LOG2 = 10
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                init,
    input  logic [1023:0]       in,
    output logic [1023:0]       out,
    output logic                valid,
    output logic                bm_init,
    output logic [1023:0]       bm_in,
    input  logic [1023:0]       bm_out,
    input  logic                bm_valid,
    output logic                mem_we,
    output logic [N_LOG2-1:0]   mem_addr,
    output logic [1023:0]       mem_wdata,
    input  logic [1023:0]       mem_rdata
);
    typedef enum logic [2:0] {IDLE, FILL, FILL_GAP, RD_ADDR, RD_DATA, MIX, DONE} state_t;
    state_t              state;
    logic [1023:0]       x;
    logic [N_LOG2-1:0]   i_cnt;
    logic [N_LOG2-1:0]   i_next;
    logic                wrap;
    assign i_next = i_cnt + 1'b1;
    assign wrap   = i_next == '0;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            x         <= '0;
            i_cnt     <= '0;
            out       <= '0;
            valid     <= 1'b0;
            bm_init   <= 1'b0;
            bm_in     <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            mem_we <= 1'b0;
            if (state != IDLE && !init) begin
                state   <= IDLE;
                bm_init <= 1'b0;
                valid   <= 1'b0;
            end else begin
                case (state)
                    IDLE: if (init) begin
                        x         <= in;
                        i_cnt     <= '0;
                        bm_init   <= 1'b1;
                        bm_in     <= in;
                        mem_we    <= 1'b1;
                        mem_addr  <= '0;
                        mem_wdata <= in;
                        state     <= FILL;
                    end
                    FILL: if (bm_valid) begin
                        x       <= bm_out;
                        i_cnt   <= i_next;
                        bm_init <= 1'b0;
                        // Integerify is taken straight from bm_out so the read address is ready in RD_ADDR
                        mem_addr <= wrap ? bm_out[512 +: N_LOG2] : mem_addr;
                        state    <= wrap ? RD_ADDR : FILL_GAP;
                    end
                    FILL_GAP: begin
                        bm_init   <= 1'b1;
                        bm_in     <= x;
                        mem_we    <= 1'b1;
                        mem_addr  <= i_cnt;
                        mem_wdata <= x;
                        state     <= FILL;
                    end
                    RD_ADDR: state <= RD_DATA;
                    RD_DATA: begin
                        bm_in   <= x ^ mem_rdata;
                        bm_init <= 1'b1;
                        state   <= MIX;
                    end
                    MIX: if (bm_valid) begin
                        x        <= bm_out;
                        i_cnt    <= i_next;
                        bm_init  <= 1'b0;
                        mem_addr <= bm_out[512 +: N_LOG2];
                        if (wrap) begin
                            out   <= bm_out;
                            valid <= 1'b1;
                            state <= DONE;
                        end else begin
                            state <= RD_ADDR;
                        end
                    end
                    DONE: state <= DONE;
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_romix_dpct_ctrl.sv
// tb_romix_dpct_ctrl: random-stimulus bench with a stub BlockMix (out = in+1) and a software ROMix model.
module tb_romix_dpct_ctrl;
    localparam int NL = 2;
    localparam int N  = 1 << NL;

    logic            clk;
    logic            reset_n;
    logic            init;
    logic [1023:0]   inp;
    logic [1023:0]   res_out;
    logic            valid;
    logic            bm_init;
    logic [1023:0]   bm_in;
    logic [1023:0]   bm_out;
    logic            bm_valid;
    logic            mem_we;
    logic [NL-1:0]   mem_addr;
    logic [1023:0]   mem_wdata;
    logic [1023:0]   mem_rdata;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int lat = 4;
    int cnt;
    logic [1023:0] mem [N];
    logic [1023:0] exp_out;

    romix_dpct_ctrl #(.N_LOG2(NL)) dut (
        .clk(clk), .reset_n(reset_n), .init(init), .in(inp), .out(res_out), .valid(valid),
        .bm_init(bm_init), .bm_in(bm_in), .bm_out(bm_out), .bm_valid(bm_valid),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Stub BlockMix: valid rises lat cycles after bm_init, drops once bm_init is low
    always_ff @(posedge clk) begin
        if (!bm_init) begin
            cnt      <= 0;
            bm_valid <= 1'b0;
        end else if (cnt == lat - 1) begin
            bm_valid <= 1'b1;
            bm_out   <= bm_in + 1'b1;
        end else begin
            cnt <= cnt + 1;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        mem_rdata <= mem[mem_addr];
    end

    function automatic logic [31:0] fold(input logic [1023:0] v);
        logic [31:0] f = '0;
        for (int k = 0; k < 32; k++) f ^= v[32*k +: 32];
        return f;
    endfunction

    task automatic check(input string tag, input logic [1023:0] got, input logic [1023:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got ..%h (fold %h) expected ..%h (fold %h)", tag, got[63:0], fold(got), exp[63:0], fold(exp));
        end
    endtask

    function automatic logic [1023:0] rand_block();
        logic [1023:0] v;
        for (int k = 0; k < 32; k++) v[32*k +: 32] = $urandom;
        return v;
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"}, valid, 0);
        check({tag, "_out"}, res_out, 0);
        check({tag, "_bm_init"}, bm_init, 0);
        check({tag, "_bm_in"}, bm_in, 0);
        check({tag, "_mem_we"}, mem_we, 0);
        check({tag, "_mem_addr"}, mem_addr, 0);
        check({tag, "_mem_wdata"}, mem_wdata, 0);
    endtask

    // Starts a job on b; returns when valid is seen, or at cycle stop_t if stop_t > 0
    task automatic run_job(input logic [1023:0] b, input int stop_t);
        logic [1023:0] v [N];
        logic [1023:0] bexp [2*N];
        int            texp [2*N];
        logic [1023:0] xm;
        logic [1023:0] y;
        int s, t, w, r;
        bit done, pb;
        xm = b;
        for (int k = 0; k < N; k++) begin
            v[k] = xm;
            bexp[k] = xm;
            texp[k] = 1 + k * (lat + 2);
            xm = xm + 1'b1;
        end
        for (int k = 0; k < N; k++) begin
            y = xm ^ v[int'(xm[512 +: NL])];
            bexp[N + k] = y;
            texp[N + k] = N * (lat + 2) + 2 + k * (lat + 3);
            xm = y + 1'b1;
        end
        exp_out = xm;
        @(negedge clk);
        init = 1'b1;
        inp = b;
        reset_n = 1'b1;
        s = cyc;
        w = 0;
        r = 0;
        done = 0;
        pb = bm_init;
        for (int n = 0; n < 3000 && !done; n++) begin
            @(negedge clk);
            t = cyc - s;
            if (mem_we) begin
                if (w < N) begin
                    check("wr_addr", mem_addr, w);
                    check("wr_data", mem_wdata, v[w]);
                    check("wr_time", t, texp[w]);
                end else check("extra_write", 1, 0);
                w++;
            end
            if (bm_init && !pb) begin
                if (r < 2 * N) begin
                    check("bm_in", bm_in, bexp[r]);
                    check("bm_start_time", t, texp[r]);
                end else check("extra_bm_start", 1, 0);
                r++;
            end
            pb = bm_init;
            if (stop_t > 0 && t == stop_t) return;
            if (valid) begin
                check("valid_time", t, N * (2 * lat + 5));
                check("out", res_out, exp_out);
                check("write_count", w, N);
                check("bm_start_count", r, 2 * N);
                done = 1;
            end
        end
        if (!done) check("timeout", 0, 1);
    endtask

    task automatic clear_init();
        init = 1'b0;
        @(negedge clk);
        check("clear_valid", valid, 0);
    endtask

    initial begin
        logic [1023:0] b;
        reset_n = 1'b0;
        init = 1'b0;
        inp = '0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");

        lat = 4;
        run_job('0, 0);
        check("out_eight", res_out, 8);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("hold_valid", valid, 1);
            check("hold_out", res_out, 8);
        end
        clear_init();
        check("clear_out_kept", res_out, 8);

        b = '0;
        b[512] = 1'b1;
        run_job(b, 0);
        clear_init();

        for (int k = 0; k < 4; k++) begin
            lat = $urandom_range(1, 6);
            run_job(rand_block(), 0);
            clear_init();
        end

        lat = 4;
        run_job('0, 20);
        init = 1'b0;
        @(negedge clk);
        check("abort_bm_init", bm_init, 0);
        check("abort_mem_we", mem_we, 0);
        check("abort_valid", valid, 0);
        run_job('0, 0);
        check("rerun_out", res_out, 8);
        clear_init();

        lat = $urandom_range(1, 6);
        run_job(rand_block(), N * (lat + 2) + 2);
        #2 reset_n = 1'b0;
        #1 check_reset_outputs("async_reset");
        @(negedge clk);
        run_job(rand_block(), 0);
        clear_init();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
